// File: rtl/aes_pkg.sv
// Shared AES types and constants for the iterative AES engines.
// Latency: none; this file holds declarations only.
// Backpressure: not applicable.
package aes_pkg;

   localparam int AES_BLOCK_W = 128;
   localparam int AES_BYTE_W  = 8;
   localparam int AES_NBYTES  = 16;

   typedef logic [AES_BYTE_W-1:0] aes_byte_t;

   // Packed so that element [15] is byte 0 (bits 127:120), element [0] is byte 15.
   typedef aes_byte_t [AES_NBYTES-1:0] aes_state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } aes_fsm_e;

endpackage

// File: rtl/aes_subbytes_seq_if.sv
// Input and output valid/ready streams of the SubBytes engine, plus its busy flag.
// Latency: none; wires only.
// Backpressure: out_ready from the consumer, in_ready back to the producer.
interface aes_subbytes_seq_if;

   logic                            in_valid;
   logic                            in_ready;
   logic [aes_pkg::AES_BLOCK_W-1:0] in_data;
   logic                            out_valid;
   logic                            out_ready;
   logic [aes_pkg::AES_BLOCK_W-1:0] out_data;
   logic                            busy;

   // Engine side.
   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output busy
   );

   // Producer/consumer side.
   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  busy
   );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box: one byte in, its substitution out, via table lookup.
// Latency: purely combinational.
// Backpressure: none.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] d
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign d = SBOX[a];

endmodule

// File: rtl/aes_subbytes_seq.sv
// Iterative AES SubBytes: substitutes a 128-bit state BYTES_PER_CYCLE bytes per clock.
// Latency: out_valid rises NGROUPS cycles after the accept edge; one block per NGROUPS+1 cycles sustained.
// Backpressure: result held in DONE until out_ready; a new block is accepted on the same edge it leaves.
module aes_subbytes_seq
   import aes_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   aes_subbytes_seq_if.slave bus
);

   localparam int NGROUPS = AES_NBYTES / BYTES_PER_CYCLE;
   localparam int GRP_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

   aes_fsm_e         state, state_nxt;
   logic [GRP_W-1:0] grp, grp_nxt;
   aes_state_t       src_reg;
   aes_state_t       res_reg;
   logic             accept;

   logic [3:0] byte_idx [BYTES_PER_CYCLE];
   aes_byte_t  sb_in    [BYTES_PER_CYCLE];
   aes_byte_t  sb_out   [BYTES_PER_CYCLE];

   assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state == BUSY);
   assign bus.out_data  = res_reg;
   assign accept        = bus.in_valid & bus.in_ready;

   // Group grp covers bytes grp*BPC .. grp*BPC+BPC-1; byte k lives in packed element 15-k.
   for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
      assign byte_idx[g] = 4'(AES_NBYTES - 1 - (int'(grp) * BYTES_PER_CYCLE + g));
      assign sb_in[g]    = src_reg[byte_idx[g]];

      aes_sbox u_sbox (
         .a (sb_in[g]),
         .d (sb_out[g])
      );
   end

   // State and group counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grp   <= '0;
      end else begin
         state <= state_nxt;
         grp   <= grp_nxt;
      end
   end

   // Next-state logic: accept from IDLE or DONE, walk groups in BUSY, hold DONE until drained.
   always_comb begin
      state_nxt = state;
      grp_nxt   = grp;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = BUSY;
               grp_nxt   = '0;
            end
         end
         BUSY: begin
            if (grp == GRP_W'(NGROUPS - 1)) begin
               state_nxt = DONE;
               grp_nxt   = '0;
            end else begin
               grp_nxt = grp + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_nxt = bus.in_valid ? BUSY : IDLE;
               grp_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            grp_nxt   = '0;
         end
      endcase
   end

   // Source capture on accept only; result bytes written group by group while BUSY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_reg <= '0;
         res_reg <= '0;
      end else begin
         if (accept) begin
            src_reg <= bus.in_data;
         end
         if (state == BUSY) begin
            for (int b = 0; b < BYTES_PER_CYCLE; b++) begin
               res_reg[byte_idx[b]] <= sb_out[b];
            end
         end
      end
   end

endmodule

// File: doc/aes_subbytes_seq.md
Name: aes_subbytes_seq

Overview:
Iterative AES SubBytes engine: the forward (encryption) counterpart of the existing inverse S-box path.
- Accepts one 128-bit state over a valid/ready handshake.
- Substitutes it BYTES_PER_CYCLE bytes per clock through replicated forward S-box instances.
- Returns the result over a second valid/ready handshake.
- Sits between AddRoundKey and ShiftRows in the encrypt datapath, trading latency for S-box area.

Parameters:
BYTES_PER_CYCLE, 4, forward S-box instances and bytes substituted per BUSY cycle; legal values 1, 2, 4, 8, 16.
NGROUPS, 16/BYTES_PER_CYCLE, derived localparam: BUSY cycles per block.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data holds a state to substitute
in_ready  output  1  engine can accept in_data this cycle
in_data  input  128  input state; byte k = in_data[127-8k -: 8], k=0..15
out_valid  output  1  out_data holds a completed result
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  128  substituted state, same byte ordering
busy  output  1  high in BUSY state

Behaviour:
- States: IDLE, BUSY, DONE. Registers: state, grp counter (clog2(NGROUPS) bits, min 1), src_reg[127:0], res_reg[127:0].
- Reset (rst_n low, asynchronous):
  - state=IDLE, grp=0, src_reg=0, res_reg=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, out_data=0.
  - Reset mid-BUSY or mid-DONE discards the block; no partial output ever appears.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational; does not depend on in_valid.
- out_valid = (state==DONE); busy = (state==BUSY); out_data = res_reg.
- Accept (in_valid & in_ready at an edge): src_reg<=in_data, grp<=0, state<=BUSY.
- BUSY edge:
  - Bytes grp*BYTES_PER_CYCLE .. grp*BYTES_PER_CYCLE+BYTES_PER_CYCLE-1 of src_reg pass through the S-boxes into the same byte positions of res_reg.
  - If grp==NGROUPS-1: state<=DONE, grp<=0; else grp<=grp+1.
- Latency: out_valid rises exactly NGROUPS cycles after the accept edge (4 for default; 1 for BYTES_PER_CYCLE=16).
- res_reg is fully overwritten every block; stale bytes never leak.
- BUSY ignores in_valid and out_ready. in_ready=0, so in_data may change freely.
- DONE:
  - out_data stable while out_valid & !out_ready; holds indefinitely under backpressure.
  - out_ready & !in_valid: state<=IDLE.
  - out_ready & in_valid: output handshake and new accept on the same edge, state<=BUSY. No bubble through IDLE.
- Sustained throughput: one block per NGROUPS+1 cycles with out_ready tied high.
- Forward S-box: standard FIPS-197 table, byte lookup, purely combinational, e.g. S(00)=63, S(52)=00, S(53)=ed, S(ff)=16.
- No X propagation from in_data when in_valid=0. src_reg loads only on accept.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W=128, AES_BYTE_W=8, AES_NBYTES=16.
  - byte typedef and state typedef (16 x byte).
  - State enum {IDLE, BUSY, DONE}, shared with other iterative AES engines.
- One sub-module, aes_sbox (forward table, 8-bit a in, 8-bit d out), instantiated BYTES_PER_CYCLE times.
- Byte-group mux and write-enable decode stay inline.

Test Plan:
- FIPS-197 vector (default param): in_data=193de3bea0f4e22b9ac68d2ae9f84808, out_ready=1 -> out_valid exactly 4 cycles after accept; out_data=d42711aee0bf98f1b8b45de51e415230.
- All-zero state, then all-ff state back-to-back with in_valid held -> 63636363...63, then 16161616...16. Second accept on the same edge as the first output handshake; period 5 cycles.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid stays 1, out_data stable, in_ready=0. Raise out_ready -> single handshake, then IDLE.
- Reset mid-operation: drop rst_n at BUSY grp=2 -> out_valid=0, in_ready=1, out_data=0 immediately (asynchronous). Next block processes correctly from grp=0.
- Parameter sweep BYTES_PER_CYCLE=1,2,8,16 with the FIPS vector -> same result; latency 16, 8, 2, 1 cycles respectively.
- Exhaustive S-box: 16 blocks covering bytes 00..ff in order -> every byte matches the FIPS-197 forward table. Round trip through the existing inverse S-box returns the original byte.
